// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and address constants for the memory port arbiter
//
// Purpose : state and grant encodings used by memory_port_arbiter and
//           mem_arb_pick, plus the text/data segment base addresses used
//           by benches that drive the arbiter.
// Ports   : none (package).
// Config  : MEM_ARB_RR_EN is consumed by mem_arb_pick and memory_port_arbiter.
package mem_arb_pkg;

    // Arbiter FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Grant encoding: which requester owns the memory port.
    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    // Segment bases of the two requesters.
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between fetch and load/store requesters
//
// Purpose : chooses which pending request is granted when the arbiter is
//           idle. Fixed priority (data over fetch) by default; with
//           MEM_ARB_RR_EN defined a tie goes to the requester that was not
//           granted last.
// Ports   : fetch_req  in  fetch request pending
//           data_req   in  load/store request pending
//           last_grant in  previous grant (only with MEM_ARB_RR_EN)
//           grant      out winning requester (GNT_FETCH / GNT_DATA)
//           any_req    out at least one request pending
// Config  : MEM_ARB_RR_EN selects round-robin tie breaking.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic fetch_req,
    input  logic data_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic grant,
    output logic any_req
);

    assign any_req = fetch_req | data_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant = GNT_FETCH;
        if (fetch_req && data_req) begin
            // Tie: hand the port to whoever did not have it last time.
            grant = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end else if (data_req) begin
            grant = GNT_DATA;
        end
    end
`else
    always_comb begin
        grant = GNT_FETCH;
        if (data_req) begin
            grant = GNT_DATA;
        end
    end
`endif

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares the single-port memory between instruction fetch and load/store
//
// Purpose : grants one requester at a time, drives the memory write-enable,
//           address and write data, waits READ_LATENCY cycles for reads,
//           captures read data into the winner's data register and pulses
//           the winner's acknowledge for one cycle.
// Ports   : clk, reset            clock, asynchronous active-high reset
//           Fetch_Req_i/Addr_i    fetch request (level, held until ack)
//           Fetch_Ack_o/Data_o    one-cycle ack, registered instruction word
//           Data_Req_i/We_i/Addr_i/Wdata_i  load/store request
//           Data_Ack_o/Rdata_o    one-cycle ack, registered load data
//           Mem_Write_Enable_o/Mem_Address_o/Mem_Write_Data_o  to memory
//           Mem_Read_Data_i       from memory
//           Busy_o                high whenever the FSM is not idle
// Config  : MEM_ARB_RR_EN enables round-robin tie breaking (last-grant register).
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Fetch_Req_i,
    input  logic [DATA_WIDTH-1:0] Fetch_Addr_i,
    output logic                  Fetch_Ack_o,
    output logic [DATA_WIDTH-1:0] Fetch_Data_o,
    input  logic                  Data_Req_i,
    input  logic                  Data_We_i,
    input  logic [DATA_WIDTH-1:0] Data_Addr_i,
    input  logic [DATA_WIDTH-1:0] Data_Wdata_i,
    output logic                  Data_Ack_o,
    output logic [DATA_WIDTH-1:0] Data_Rdata_o,
    output logic                  Mem_Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
    output logic                  Busy_o
);

    localparam int              CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  grant_q;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  fetch_ack;
    logic                  data_ack;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic [DATA_WIDTH-1:0] data_rdata;

    logic                  pick_grant;
    logic                  pick_any;
    logic                  pick_is_data;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    mem_arb_pick u_pick (
        .fetch_req (Fetch_Req_i),
        .data_req  (Data_Req_i),
        .last_grant(last_grant),
        .grant     (pick_grant),
        .any_req   (pick_any)
    );

    // Updated on every grant, not only on ties, so alternation follows the
    // actual order of service.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_DATA;
        end else if (state == ST_IDLE && pick_any) begin
            last_grant <= pick_grant;
        end
    end
`else
    mem_arb_pick u_pick (
        .fetch_req(Fetch_Req_i),
        .data_req (Data_Req_i),
        .grant    (pick_grant),
        .any_req  (pick_any)
    );
`endif

    assign pick_is_data = (pick_grant == GNT_DATA);

    // Requests are only sampled in IDLE; once granted the transaction runs to
    // completion even if the requester drops its request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            grant_q    <= GNT_DATA;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fetch_ack  <= 1'b0;
            data_ack   <= 1'b0;
            fetch_data <= '0;
            data_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q  <= pick_grant;
                        mem_addr <= pick_is_data ? Data_Addr_i : Fetch_Addr_i;
                        mem_we   <= pick_is_data & Data_We_i;
                        if (pick_is_data) begin
                            mem_wdata <= Data_Wdata_i;
                        end
                        cnt   <= CNT_LOAD;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_we) begin
                        // Stores take a single ACCESS cycle regardless of latency.
                        mem_we   <= 1'b0;
                        cnt      <= '0;
                        data_ack <= 1'b1;
                        state    <= ST_RESP;
                    end else if (cnt <= CNT_ONE) begin
                        // Last ACCESS cycle: address has been stable long enough.
                        cnt <= '0;
                        if (grant_q == GNT_DATA) begin
                            data_rdata <= Mem_Read_Data_i;
                            data_ack   <= 1'b1;
                        end else begin
                            fetch_data <= Mem_Read_Data_i;
                            fetch_ack  <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    fetch_ack <= 1'b0;
                    data_ack  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Fetch_Ack_o        = fetch_ack;
    assign Fetch_Data_o       = fetch_data;
    assign Data_Ack_o         = data_ack;
    assign Data_Rdata_o       = data_rdata;
    assign Mem_Write_Enable_o = mem_we;
    assign Mem_Address_o      = mem_addr;
    assign Mem_Write_Data_o   = mem_wdata;
    assign Busy_o             = (state != ST_IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - scoreboard bench for memory_port_arbiter at READ_LATENCY 1 and 3
module tb_memory_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bit cur = 1'b0;   // 0: latency-1 instance active, 1: latency-3 instance active

    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] mem_rdata;

    logic        f_ack_v [2];
    logic [31:0] f_data_v [2];
    logic        d_ack_v [2];
    logic [31:0] d_rdata_v [2];
    logic        m_we_v [2];
    logic [31:0] m_addr_v [2];
    logic [31:0] m_wdata_v [2];
    logic        busy_v [2];

    memory_port_arbiter #(.DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .Fetch_Req_i(fetch_req && !cur), .Fetch_Addr_i(fetch_addr),
        .Fetch_Ack_o(f_ack_v[0]), .Fetch_Data_o(f_data_v[0]),
        .Data_Req_i(data_req && !cur), .Data_We_i(data_we),
        .Data_Addr_i(data_addr), .Data_Wdata_i(data_wdata),
        .Data_Ack_o(d_ack_v[0]), .Data_Rdata_o(d_rdata_v[0]),
        .Mem_Write_Enable_o(m_we_v[0]), .Mem_Address_o(m_addr_v[0]),
        .Mem_Write_Data_o(m_wdata_v[0]), .Mem_Read_Data_i(mem_rdata),
        .Busy_o(busy_v[0])
    );

    memory_port_arbiter #(.DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .Fetch_Req_i(fetch_req && cur), .Fetch_Addr_i(fetch_addr),
        .Fetch_Ack_o(f_ack_v[1]), .Fetch_Data_o(f_data_v[1]),
        .Data_Req_i(data_req && cur), .Data_We_i(data_we),
        .Data_Addr_i(data_addr), .Data_Wdata_i(data_wdata),
        .Data_Ack_o(d_ack_v[1]), .Data_Rdata_o(d_rdata_v[1]),
        .Mem_Write_Enable_o(m_we_v[1]), .Mem_Address_o(m_addr_v[1]),
        .Mem_Write_Data_o(m_wdata_v[1]), .Mem_Read_Data_i(mem_rdata),
        .Busy_o(busy_v[1])
    );

    wire        fetch_ack  = f_ack_v[cur];
    wire [31:0] fetch_data = f_data_v[cur];
    wire        data_ack   = d_ack_v[cur];
    wire [31:0] data_rdata = d_rdata_v[cur];
    wire        mem_we     = m_we_v[cur];
    wire [31:0] mem_addr   = m_addr_v[cur];
    wire [31:0] mem_wdata  = m_wdata_v[cur];
    wire        busy       = busy_v[cur];

    function automatic logic [5:0] idx(input logic [31:0] a);
        return {a[28], a[6:2]};
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Memory model: combinational read that only becomes valid once the
    // address has been stable for the configured latency.
    logic [31:0] mem [64];
    bit          inited = 1'b0;
    logic [31:0] last_addr = '1;
    int          age = 0;

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            inited <= 1'b1;
        end else if (mem_we) begin
            mem[idx(mem_addr)] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_addr != last_addr) begin
            last_addr = mem_addr;
            age = 0;
        end else begin
            age++;
        end
    end

    assign mem_rdata = (mem_addr == last_addr && age >= (cur ? 2 : 0))
                       ? mem[idx(mem_addr)] : 32'hBAD0_BAD0;

    // Reference model and scoreboard.
    logic [31:0] ref_mem [64];
    logic [31:0] model_rdata = '0;
    logic [31:0] fq[$];
    logic [31:0] dq[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_ack) begin
            if (fq.size() == 0) begin
                total++; bad++;
                $display("FAIL fetch_unexpected_ack: got ack=1 expected no ack");
            end else begin
                check("fetch_data", fetch_data, fq.pop_front());
            end
        end
        if (data_ack) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL data_unexpected_ack: got ack=1 expected no ack");
            end else begin
                check("data_rdata", data_rdata, dq.pop_front());
            end
        end
    end

    task automatic xfer(input bit is_data, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat_cyc, output int busy_cyc,
                        output int we_cyc, output int addr_bad);
        bit got;
        if (is_data) begin
            if (we) begin
                ref_mem[idx(addr)] = wdata;
                dq.push_back(model_rdata);
            end else begin
                model_rdata = ref_mem[idx(addr)];
                dq.push_back(model_rdata);
            end
            data_we = we; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
        end else begin
            fq.push_back(ref_mem[idx(addr)]);
            fetch_addr = addr; fetch_req = 1'b1;
        end
        lat_cyc = 0; busy_cyc = 0; we_cyc = 0; addr_bad = 0;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            lat_cyc++;
            got = is_data ? data_ack : fetch_ack;
            if (busy) busy_cyc++;
            if (mem_we) we_cyc++;
            if (busy && !got && mem_addr !== addr) addr_bad++;
            if (!got && lat_cyc >= 300) begin
                total++; bad++;
                $display("FAIL xfer_timeout: got no ack after %0d cycles expected ack", lat_cyc);
                got = 1'b1;
            end
        end
        if (is_data) data_req = 1'b0; else fetch_req = 1'b0;
    endtask

    task automatic fetch_proc(input int n);
        int l, b, w, a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(1'b0, 1'b0, TEXT_BASE + ($urandom_range(0, 31) << 2), '0, l, b, w, a);
        end
    endtask

    task automatic data_proc(input int n);
        int l, b, w, a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(1'b1, 1'($urandom_range(0, 1)), DATA_BASE + ($urandom_range(0, 31) << 2),
                 $urandom, l, b, w, a);
        end
    endtask

    task automatic tie_test();
        int fc, dc, want_f, want_d;
        int order[$];
        int exp_order[$];
        fc = 0; dc = 0;
`ifdef MEM_ARB_RR_EN
        want_f = 2; want_d = 2;
        exp_order.push_back(0); exp_order.push_back(1);
        exp_order.push_back(0); exp_order.push_back(1);
`else
        want_f = 1; want_d = 4;
        for (int i = 0; i < 4; i++) exp_order.push_back(1);
        exp_order.push_back(0);
`endif
        for (int i = 0; i < want_f; i++) fq.push_back(ref_mem[idx(TEXT_BASE + 4)]);
        model_rdata = ref_mem[idx(DATA_BASE)];
        for (int i = 0; i < want_d; i++) dq.push_back(model_rdata);
        fetch_addr = TEXT_BASE + 4; data_addr = DATA_BASE; data_we = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1;
        for (int k = 0; k < 200 && (fc < want_f || dc < want_d); k++) begin
            @(negedge clk);
            if (fetch_ack) begin
                order.push_back(0); fc++;
                if (fc == want_f) fetch_req = 1'b0;
            end
            if (data_ack) begin
                order.push_back(1); dc++;
                if (dc == want_d) data_req = 1'b0;
            end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        check("tie_grant_count", order.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < order.size(); i++)
            check($sformatf("tie_grant_%0d", i), order[i], exp_order[i]);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, b, w, a, k;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fetch_ack", fetch_ack, 0);
        check("rst_data_ack", data_ack, 0);
        check("rst_fetch_data", fetch_data, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        xfer(1'b0, 1'b0, TEXT_BASE, '0, l, b, w, a);
        check("fetch_ack_cycle", l, 2);
        check("fetch_we_cycles", w, 0);
        @(negedge clk);
        xfer(1'b1, 1'b1, DATA_BASE, 32'h1234_5678, l, b, w, a);
        check("store_ack_cycle", l, 2);
        check("store_we_cycles", w, 1);
        @(negedge clk);
        xfer(1'b1, 1'b0, DATA_BASE, '0, l, b, w, a);
        check("load_ack_cycle", l, 2);
        @(negedge clk);

        tie_test();

        // Abort a store in its ACCESS cycle.
        data_we = 1'b1; data_addr = DATA_BASE + 8; data_wdata = 32'hFFFF_FFFF; data_req = 1'b1;
        @(negedge clk);
        check("abort_we_in_access", mem_we, 1);
        #1 reset = 1'b1; data_req = 1'b0;
        #1;
        check("abort_we_async_drop", mem_we, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        check("abort_rdata_cleared", data_rdata, 0);
        @(negedge clk);
        xfer(1'b1, 1'b1, DATA_BASE + 8, 32'hFFFF_FFFF, l, b, w, a);
        check("reissue_store_cycle", l, 2);
        @(negedge clk);
        xfer(1'b1, 1'b0, DATA_BASE + 8, '0, l, b, w, a);
        @(negedge clk);

        fork
            fetch_proc(20);
            data_proc(25);
        join
        repeat (2) @(negedge clk);

        // Switch to the latency-3 instance.
        cur = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
        @(negedge clk);

        xfer(1'b0, 1'b0, TEXT_BASE + 8, '0, l, b, w, a);
        check("lat3_ack_cycle", l, 4);
        check("lat3_busy_cycles", b, 4);
        check("lat3_addr_unstable", a, 0);
        @(negedge clk);

        // Fetch request dropped right after the grant.
        fq.push_back(ref_mem[idx(TEXT_BASE + 12)]);
        fetch_addr = TEXT_BASE + 12; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        k = 1;
        while (!fetch_ack && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("drop_ack_cycle", k, 4);
        @(negedge clk);
        check("drop_busy_after", busy, 0);
        repeat (3) @(negedge clk);

        fork
            fetch_proc(20);
            data_proc(25);
        join
        repeat (3) @(negedge clk);

        check("fetch_queue_drained", fq.size(), 0);
        check("data_queue_drained", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
